oled_update_arbiter: RTL

- Shares one OLED display controller between NUM_REQ independent requesters; each requester supplies a full 4-page frame of 4 x 128 bits.
- Selects requesters round-robin and latches the winner's frame onto the controller's page inputs.
- Sequences the controller's EN/FIN handshake, then enforces a minimum idle gap before the next update.
- Sits between application logic (hex/text formatters) and the display controller. Both share CLK and RST.

---
 rtl/oled_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/oled_update_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/oled_arb_pkg.sv
// Shared types and constants for the OLED update arbiter: FSM state encoding,
// default page/frame widths and the blank frame loaded on reset.
package oled_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FIN = 2'd1,
    RELEASE  = 2'd2,
    GAP      = 2'd3
  } state_e;

  localparam int PAGE_W  = 128;
  localparam int FRAME_W = 4 * PAGE_W;

  localparam logic [FRAME_W-1:0] BLANK_FRAME = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping back to index 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] rotated;
  int                   pos;

  // Rotating the doubled vector puts rr_ptr at bit 0; the lowest set bit wins,
  // so the scan runs downward and the last hit is kept.
  always_comb begin
    rotated = {req, req} >> rr_ptr;
    winner  = '0;
    onehot  = '0;
    pos     = 0;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        pos = int'(rr_ptr) + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        winner = PTR_W'(pos);
      end
    end
    if (any_req) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/oled_update_arbiter.sv
// Shares one OLED controller between NUM_REQ requesters: round-robin grant,
// frame capture, EN/FIN handshake with watchdog, and a post-update idle gap.
module oled_update_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PAGE_W  = oled_arb_pkg::PAGE_W,
  parameter int MIN_GAP = 16,
  parameter int TIMEOUT = 2**24
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*4*PAGE_W-1:0] req_pages,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        oled_en,
  output logic [PAGE_W-1:0]           oled_page0,
  output logic [PAGE_W-1:0]           oled_page1,
  output logic [PAGE_W-1:0]           oled_page2,
  output logic [PAGE_W-1:0]           oled_page3,
  input  logic                        oled_fin,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [1:0]                  state_dbg
);
  import oled_arb_pkg::*;

  // Handshake: oled_en rises with the captured frame and stays high until
  // oled_fin is sampled high (or the watchdog expires); the controller must
  // then drop oled_fin before the arbiter leaves RELEASE.

  localparam int FRAME_BITS = 4 * PAGE_W;
  localparam int PTR_W      = $clog2(NUM_REQ);
  localparam int WD_W       = $clog2(TIMEOUT);
  localparam int GAP_W      = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_d, done_d;
  logic                    en_d, busy_d, terr_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [GAP_W-1:0]        gap_q, gap_d;

  logic [PTR_W-1:0]        winner;
  logic [NUM_REQ-1:0]      onehot;
  logic                    any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (req),
    .rr_ptr  (ptr_q),
    .winner  (winner),
    .onehot  (onehot),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    done_d  = '0;
    en_d    = oled_en;
    terr_d  = timeout_err;
    frame_d = frame_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          frame_d = req_pages[winner*FRAME_BITS +: FRAME_BITS];
          grant_d = onehot;
          en_d    = 1'b1;
          ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          wd_d    = '0;
          state_d = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        // FIN is checked first so it wins a tie with watchdog expiry.
        if (oled_fin) begin
          en_d    = 1'b0;
          done_d  = grant;
          grant_d = '0;
          state_d = RELEASE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          en_d    = 1'b0;
          grant_d = '0;
          terr_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!oled_fin) begin
          if (MIN_GAP == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_W'(MIN_GAP - 1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      grant       <= '0;
      done        <= '0;
      oled_en     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frame_q     <= FRAME_BITS'(BLANK_FRAME);
      ptr_q       <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      done        <= done_d;
      oled_en     <= en_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
      frame_q     <= frame_d;
      ptr_q       <= ptr_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
    end
  end

  assign oled_page0 = frame_q[4*PAGE_W-1 -: PAGE_W];
  assign oled_page1 = frame_q[3*PAGE_W-1 -: PAGE_W];
  assign oled_page2 = frame_q[2*PAGE_W-1 -: PAGE_W];
  assign oled_page3 = frame_q[PAGE_W-1:0];
  assign state_dbg  = state_q;

endmodule
